ahb_dma_mem_responder: RTL and testbench
========================================

AHB_DMA_MEM_RESPONDER -- requirements
Module: ahb_dma_mem_responder

Interface
REQ-001 SHALL have parameter MEM_AWIDTH, default 10, word-address bits (depth 2^MEM_AWIDTH x 32).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base of the memory window.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0-7, data-phase wait cycles per transfer.
REQ-004 SHALL have ports HCLK in 1, single clock; HRESETN in 1, asynchronous active-low reset.
REQ-005 SHALL have ports TXHBUSREQ in 1; TXHTRANS in 2; TXHADDR in 32; TXHWRITE in 1; TXHWDATA in 32 (TX-DMA master request side).
REQ-006 SHALL have ports TXHGRANT out 1; TXHRESP out 2; TXHRDATA out 32 (TX-DMA response side).
REQ-007 SHALL have ports RXHBUSREQ, RXHTRANS, RXHADDR, RXHWRITE, RXHWDATA in, and RXHGRANT, RXHRESP, RXHRDATA out, all with widths matching the TX set.
REQ-008 SHALL have port HREADY out 1, shared ready driven to both masters.

Function
REQ-009 SHALL act as an AHB slave memory and two-master arbiter serving the MAC TX-DMA and RX-DMA masters.
REQ-010 Ownership SHALL be held in register owner (TX/RX); exactly one grant SHALL be high at all times; grant SHALL equal next owner.
REQ-011 Re-arbitration SHALL occur only in cycles with HREADY=1 and when the owner's HTRANS is IDLE or its HBUSREQ=0.
REQ-012 On re-arbitration with both requesting, the master not served last SHALL win; with one requesting, that master SHALL win; with none requesting, ownership SHALL stay parked.
REQ-013 An address phase SHALL be accepted from the current owner when HREADY=1 and HTRANS is NONSEQ(2'b10) or SEQ(2'b11).
REQ-014 IDLE(00)/BUSY(01) SHALL get a zero-wait OKAY response.
REQ-015 The data phase SHALL follow acceptance, with HREADY low for WAIT_STATES cycles, then high for 1 cycle.
REQ-016 Writes SHALL store the owner's HWDATA at the last data-phase cycle.
REQ-017 Reads SHALL present the word on the accessing master's HRDATA in the last data-phase cycle; the non-accessing master's HRDATA SHALL be 0.
REQ-018 Word index SHALL be (HADDR-BASE_ADDR)[MEM_AWIDTH+1:2]; HADDR[1:0] SHALL be ignored (word accesses only).
REQ-019 A read of an address written in the immediately preceding data phase SHALL return the new data (write-to-read forwarding).
REQ-020 Data-phase state SHALL be kept in an FSM with states IDLE, WAIT, DATA, ERR1, ERR2.

Reset
REQ-021 HRESETN low SHALL asynchronously force state IDLE, owner=TX, last-served=RX, HREADY=1, TXHGRANT=1, RXHGRANT=0, both HRESP=OKAY, both HRDATA=0, wait counter=0.
REQ-022 Memory contents SHALL NOT be cleared by reset.
REQ-023 Reset asserted mid-transfer SHALL abort the pending write with no memory update.

Configuration
REQ-024 With AHB_DMA_MEM_ERR_EN defined, accesses outside [BASE_ADDR, BASE_ADDR+4*2^MEM_AWIDTH) SHALL get the two-cycle ERROR response and no memory access: ERR1 (HREADY=0, HRESP=2'b01), then ERR2 (HREADY=1, HRESP=2'b01).
REQ-025 Without AHB_DMA_MEM_ERR_EN, addresses SHALL wrap modulo depth, responses SHALL always be OKAY, and states ERR1/ERR2 SHALL not exist.

Structure
REQ-026 Package ahb_dma_mem_pkg SHALL hold HTRANS/HRESP encodings, the FSM state type, and the owner encoding.
REQ-027 Arbitration (REQ-010..012) SHALL be sub-module ahb_dma_mem_arb; memory, FSM and response muxing SHALL stay in the top module.

Verification
REQ-028 Scenario: WAIT_STATES=0, TX writes 32'hDEAD_BEEF to 0x10 then reads 0x10 back-to-back -> TXHRDATA=32'hDEAD_BEEF in the cycle after the read address phase, HREADY never low.
REQ-029 Scenario: WAIT_STATES=3, RX single read -> HREADY low 3 cycles, then high with valid RXHRDATA, RXHRESP=OKAY.
REQ-030 Scenario: both HBUSREQ high continuously, 4-beat bursts -> grants alternate TX, RX, TX, RX at burst boundaries; no grant change while SEQ is in flight.
REQ-031 Scenario: with AHB_DMA_MEM_ERR_EN, MEM_AWIDTH=10, read of BASE_ADDR+0x1000 -> ERR1 then ERR2 response, memory unchanged; without the macro -> reads word 0, OKAY.
REQ-032 Scenario: HRESETN pulsed low during the WAIT of a write to 0x20 -> outputs at reset values immediately; later read of 0x20 returns prior contents.
REQ-033 Scenario: no requests after RX activity -> RXHGRANT stays 1 (parked), IDLE transfers get OKAY with zero wait.

Source files
------------

// File: rtl/ahb_dma_mem_pkg.sv
// ahb_dma_mem_pkg: AHB encodings, data-phase FSM states and bus-owner encoding.
// AHB_DMA_MEM_ERR_EN adds the ERROR-response states to the FSM type.
package ahb_dma_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

`ifdef AHB_DMA_MEM_ERR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} dp_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} dp_state_t;
`endif

    typedef enum logic {OWN_TX = 1'b0, OWN_RX = 1'b1} owner_t;

endpackage

// File: rtl/ahb_dma_mem_arb.sv
// ahb_dma_mem_arb: two-master arbiter; alternates under contention, parks on the owner when idle.
module ahb_dma_mem_arb
    import ahb_dma_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hready,
    input  logic       accept,
    input  logic       tx_req,
    input  logic [1:0] tx_trans,
    input  logic       rx_req,
    input  logic [1:0] rx_trans,
    output owner_t     owner,
    output logic       tx_grant,
    output logic       rx_grant
);

    owner_t     last, owner_d;
    logic       own_req, rearb;
    logic [1:0] own_trans;

    always_comb begin
        own_req   = owner == OWN_TX ? tx_req : rx_req;
        own_trans = owner == OWN_TX ? tx_trans : rx_trans;
        rearb     = hready && (own_trans == HTRANS_IDLE || !own_req);
        owner_d   = owner;
        if (rearb && tx_req && rx_req)
            owner_d = last == OWN_TX ? OWN_RX : OWN_TX;
        else if (rearb && (tx_req || rx_req))
            owner_d = tx_req ? OWN_TX : OWN_RX;
    end

    // Grant is held on TX for the whole reset, whatever the request inputs do.
    assign tx_grant = !rst_n || owner_d == OWN_TX;
    assign rx_grant = rst_n && owner_d == OWN_RX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWN_TX;
            last  <= OWN_RX;
        end else begin
            owner <= owner_d;
            if (accept)
                last <= owner;
        end
    end

endmodule

// File: rtl/ahb_dma_mem_responder.sv
// ahb_dma_mem_responder: AHB slave word memory shared by the MAC TX-DMA and RX-DMA masters.
// Define AHB_DMA_MEM_ERR_EN to give out-of-window accesses a two-cycle ERROR response.
module ahb_dma_mem_responder
    import ahb_dma_mem_pkg::*;
#(
    parameter int          MEM_AWIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        TXHBUSREQ,
    input  logic [1:0]  TXHTRANS,
    input  logic [31:0] TXHADDR,
    input  logic        TXHWRITE,
    input  logic [31:0] TXHWDATA,
    output logic        TXHGRANT,
    output logic [1:0]  TXHRESP,
    output logic [31:0] TXHRDATA,
    input  logic        RXHBUSREQ,
    input  logic [1:0]  RXHTRANS,
    input  logic [31:0] RXHADDR,
    input  logic        RXHWRITE,
    input  logic [31:0] RXHWDATA,
    output logic        RXHGRANT,
    output logic [1:0]  RXHRESP,
    output logic [31:0] RXHRDATA,
    output logic        HREADY
);

    localparam int         DEPTH     = 1 << MEM_AWIDTH;
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    owner_t                owner, dp_owner;
    dp_state_t             state, state_d, start_st;
    logic [31:0]           mem [DEPTH];
    logic [1:0]            o_trans;
    logic [31:0]           o_addr, offset, dp_wdata, rd_q;
    logic                  o_write, accept, dp_write, fwd, err_phase, rd_valid, unused_bits;
    logic [MEM_AWIDTH-1:0] idx, dp_idx;
    logic [2:0]            wcnt;

    ahb_dma_mem_arb u_arb (
        .clk      (HCLK),
        .rst_n    (HRESETN),
        .hready   (HREADY),
        .accept   (accept),
        .tx_req   (TXHBUSREQ),
        .tx_trans (TXHTRANS),
        .rx_req   (RXHBUSREQ),
        .rx_trans (RXHTRANS),
        .owner    (owner),
        .tx_grant (TXHGRANT),
        .rx_grant (RXHGRANT)
    );

    assign o_trans     = owner == OWN_TX ? TXHTRANS : RXHTRANS;
    assign o_addr      = owner == OWN_TX ? TXHADDR : RXHADDR;
    assign o_write     = owner == OWN_TX ? TXHWRITE : RXHWRITE;
    assign dp_wdata    = dp_owner == OWN_TX ? TXHWDATA : RXHWDATA;
    assign offset      = o_addr - BASE_ADDR;
    assign idx         = offset[MEM_AWIDTH+1:2];
    assign unused_bits = ^{offset[1:0], offset[31:MEM_AWIDTH+2]};
    assign accept      = HREADY && (o_trans == HTRANS_NONSEQ || o_trans == HTRANS_SEQ);
    // A read right behind a write to the same word takes the data still on the bus.
    assign fwd         = state == ST_DATA && dp_write && dp_idx == idx;

`ifdef AHB_DMA_MEM_ERR_EN
    assign start_st  = offset[31:MEM_AWIDTH+2] != '0 ? ST_ERR1 : WAIT_STATES == 0 ? ST_DATA : ST_WAIT;
    assign HREADY    = state != ST_WAIT && state != ST_ERR1;
    assign err_phase = state == ST_ERR1 || state == ST_ERR2;
`else
    assign start_st  = WAIT_STATES == 0 ? ST_DATA : ST_WAIT;
    assign HREADY    = state != ST_WAIT;
    assign err_phase = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            ST_WAIT: state_d = wcnt == 3'd0 ? ST_DATA : ST_WAIT;
`ifdef AHB_DMA_MEM_ERR_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: state_d = accept ? start_st : ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state    <= ST_IDLE;
            dp_owner <= OWN_TX;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            rd_q     <= '0;
            wcnt     <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                dp_owner <= owner;
                dp_write <= o_write;
                dp_idx   <= idx;
                rd_q     <= fwd ? dp_wdata : mem[idx];
                wcnt     <= WAIT_LOAD;
            end else if (state == ST_WAIT) begin
                wcnt <= wcnt - 3'd1;
            end
        end
    end

    // No reset on the array: contents survive HRESETN, and reset leaves state IDLE so no write lands.
    always_ff @(posedge HCLK) begin
        if (state == ST_DATA && dp_write)
            mem[dp_idx] <= dp_wdata;
    end

    assign rd_valid = state == ST_DATA && !dp_write;
    assign TXHRDATA = rd_valid && dp_owner == OWN_TX ? rd_q : '0;
    assign RXHRDATA = rd_valid && dp_owner == OWN_RX ? rd_q : '0;
    assign TXHRESP  = err_phase && dp_owner == OWN_TX ? HRESP_ERROR : HRESP_OKAY;
    assign RXHRESP  = err_phase && dp_owner == OWN_RX ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_dma_mem_responder.sv
// tb_ahb_dma_mem_responder: directed checks on a zero-wait and a three-wait-state instance
// sharing one set of master inputs; each scenario resets first and checks only its instance.
module tb_ahb_dma_mem_responder;

    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_NS   = 2'b10;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_req, rx_req, tx_write, rx_write;
    logic [1:0]  tx_trans, rx_trans;
    logic [31:0] tx_addr, rx_addr, tx_wdata, rx_wdata;
    logic        g_tx0, g_rx0, rdy0, g_tx3, g_rx3, rdy3;
    logic [1:0]  rs_tx0, rs_rx0, rs_tx3, rs_rx3;
    logic [31:0] rd_tx0, rd_rx0, rd_tx3, rd_rx3;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    ahb_dma_mem_responder #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETN(rst_n),
        .TXHBUSREQ(tx_req), .TXHTRANS(tx_trans), .TXHADDR(tx_addr), .TXHWRITE(tx_write), .TXHWDATA(tx_wdata),
        .TXHGRANT(g_tx0), .TXHRESP(rs_tx0), .TXHRDATA(rd_tx0),
        .RXHBUSREQ(rx_req), .RXHTRANS(rx_trans), .RXHADDR(rx_addr), .RXHWRITE(rx_write), .RXHWDATA(rx_wdata),
        .RXHGRANT(g_rx0), .RXHRESP(rs_rx0), .RXHRDATA(rd_rx0),
        .HREADY(rdy0)
    );

    ahb_dma_mem_responder #(.WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETN(rst_n),
        .TXHBUSREQ(tx_req), .TXHTRANS(tx_trans), .TXHADDR(tx_addr), .TXHWRITE(tx_write), .TXHWDATA(tx_wdata),
        .TXHGRANT(g_tx3), .TXHRESP(rs_tx3), .TXHRDATA(rd_tx3),
        .RXHBUSREQ(rx_req), .RXHTRANS(rx_trans), .RXHADDR(rx_addr), .RXHWRITE(rx_write), .RXHWDATA(rx_wdata),
        .RXHGRANT(g_rx3), .RXHRESP(rs_rx3), .RXHRDATA(rd_rx3),
        .HREADY(rdy3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        tx_req = 0; tx_trans = TR_IDLE; tx_addr = 0; tx_write = 0; tx_wdata = 0;
        rx_req = 0; rx_trans = TR_IDLE; rx_addr = 0; rx_write = 0; rx_wdata = 0;
    endtask

    task automatic drv(input bit m, input logic req, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
        if (m) begin
            rx_req = req; rx_trans = tr; rx_addr = a; rx_write = w; rx_wdata = d;
        end else begin
            tx_req = req; tx_trans = tr; tx_addr = a; tx_write = w; tx_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_all();
        rx_req = 1;
        @(posedge clk);
        #2;
        tests++; if ({rdy0, g_tx0, g_rx0, rs_tx0, rs_rx0} !== 7'b1100000) begin fails++; $display("FAIL reset_ctl0 got %b want 1100000", {rdy0, g_tx0, g_rx0, rs_tx0, rs_rx0}); end
        tests++; if ({rd_tx0, rd_rx0} !== 64'h0) begin fails++; $display("FAIL reset_rdata0 got %h want 0", {rd_tx0, rd_rx0}); end
        tests++; if ({rdy3, g_tx3, g_rx3, rs_tx3, rs_rx3} !== 7'b1100000) begin fails++; $display("FAIL reset_ctl3 got %b want 1100000", {rdy3, g_tx3, g_rx3, rs_tx3, rs_rx3}); end
        tests++; if ({rd_tx3, rd_rx3} !== 64'h0) begin fails++; $display("FAIL reset_rdata3 got %h want 0", {rd_tx3, rd_rx3}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(); drv(0, 1, TR_NS, 32'h10, 1, 0); #2;
        tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL b2b_rdy_wr got %b want 1", rdy0); end
        cyc(); drv(0, 1, TR_NS, 32'h10, 0, 32'hDEAD_BEEF); #2;
        tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL b2b_rdy_rd got %b want 1", rdy0); end
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 0); #2;
        tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL b2b_rdy_data got %b want 1", rdy0); end
        tests++; if (rd_tx0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_fwd_rdata got %h want deadbeef", rd_tx0); end
        tests++; if (rd_rx0 !== 32'h0) begin fails++; $display("FAIL b2b_other_rdata got %h want 0", rd_rx0); end
        cyc(); drv(0, 1, TR_NS, 32'h13, 0, 0); #2;
        tests++; if (rd_tx0 !== 32'h0) begin fails++; $display("FAIL b2b_idle_rdata got %h want 0", rd_tx0); end
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 0); #2;
        tests++; if (rd_tx0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_mem_rdata got %h want deadbeef", rd_tx0); end
    endtask

    task automatic test_wait_states();
        do_reset();
        cyc(); drv(1, 1, TR_IDLE, 0, 0, 0); #2;
        tests++; if ({g_tx3, g_rx3} !== 2'b01) begin fails++; $display("FAIL ws_grant got %b want 01", {g_tx3, g_rx3}); end
        cyc(); drv(1, 1, TR_NS, 32'h40, 1, 0);
        cyc(); drv(1, 1, TR_IDLE, 0, 0, 32'h1234_5678); #2;
        tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL ws_wr_wait1 got %b want 0", rdy3); end
        cyc(); #2;
        tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL ws_wr_wait2 got %b want 0", rdy3); end
        cyc(); #2;
        tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL ws_wr_wait3 got %b want 0", rdy3); end
        cyc(); #2;
        tests++; if (rdy3 !== 1'b1) begin fails++; $display("FAIL ws_wr_data got %b want 1", rdy3); end
        cyc(); drv(1, 1, TR_NS, 32'h40, 0, 0);
        cyc(); drv(1, 1, TR_IDLE, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #2;
            tests++; if ({rdy3, rd_rx3} !== {1'b0, 32'h0}) begin fails++; $display("FAIL ws_rd_wait%0d got rdy=%b data=%h want rdy=0 data=0", i, rdy3, rd_rx3); end
            cyc();
        end
        #2;
        tests++; if (rdy3 !== 1'b1) begin fails++; $display("FAIL ws_rd_rdy got %b want 1", rdy3); end
        tests++; if (rd_rx3 !== 32'h1234_5678) begin fails++; $display("FAIL ws_rd_rdata got %h want 12345678", rd_rx3); end
        tests++; if ({rs_rx3, rd_tx3} !== 34'h0) begin fails++; $display("FAIL ws_rd_resp got resp=%b txdata=%h want 00/0", rs_rx3, rd_tx3); end
    endtask

    task automatic test_burst_alternation();
        do_reset();
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 0); drv(1, 1, TR_IDLE, 0, 0, 0); #2;
        tests++; if ({g_tx0, g_rx0} !== 2'b10) begin fails++; $display("FAIL burst_first got %b want 10", {g_tx0, g_rx0}); end
        for (int b = 0; b < 4; b++) begin
            bit m;
            m = b[0];
            for (int i = 0; i < 4; i++) begin
                cyc();
                drv(m, 1, i == 0 ? TR_NS : TR_SEQ, 32'((m ? 32'h200 : 32'h100) + 4 * i), 1, 32'(i));
                drv(!m, 1, TR_IDLE, 0, 0, 0);
                #2;
                tests++; if ({g_tx0, g_rx0} !== (m ? 2'b01 : 2'b10)) begin fails++; $display("FAIL burst_hold b%0d beat%0d got %b want %b", b, i, {g_tx0, g_rx0}, m ? 2'b01 : 2'b10); end
            end
            cyc(); drv(m, 1, TR_IDLE, 0, 0, 0); #2;
            tests++; if ({g_tx0, g_rx0} !== (m ? 2'b10 : 2'b01)) begin fails++; $display("FAIL burst_switch b%0d got %b want %b", b, {g_tx0, g_rx0}, m ? 2'b10 : 2'b01); end
        end
        idle_all();
    endtask

    task automatic test_park();
        do_reset();
        cyc(); drv(1, 1, TR_IDLE, 0, 0, 0); #2;
        tests++; if ({g_tx0, g_rx0} !== 2'b01) begin fails++; $display("FAIL park_req got %b want 01", {g_tx0, g_rx0}); end
        cyc(); drv(1, 1, TR_NS, 32'h0, 0, 0);
        cyc(); idle_all(); #2;
        tests++; if ({g_tx0, g_rx0, rdy0} !== 3'b011) begin fails++; $display("FAIL park_release got %b want 011", {g_tx0, g_rx0, rdy0}); end
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            tests++; if ({g_tx0, g_rx0, rdy0, rs_tx0, rs_rx0} !== 7'b0110000) begin fails++; $display("FAIL park_idle%0d got %b want 0110000", i, {g_tx0, g_rx0, rdy0, rs_tx0, rs_rx0}); end
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        cyc(); drv(0, 1, TR_NS, 32'h0, 1, 0);
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 32'hA5A5_0001);
        cyc(); drv(0, 1, TR_NS, 32'h1000, 0, 0); #2;
        tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL oor_addr_rdy got %b want 1", rdy0); end
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 0); #2;
`ifdef AHB_DMA_MEM_ERR_EN
        tests++; if ({rdy0, rs_tx0, rs_rx0} !== 5'b0_01_00) begin fails++; $display("FAIL oor_err1 got %b want 00100", {rdy0, rs_tx0, rs_rx0}); end
        cyc(); #2;
        tests++; if ({rdy0, rs_tx0, rd_tx0} !== {1'b1, 2'b01, 32'h0}) begin fails++; $display("FAIL oor_err2 got rdy=%b resp=%b data=%h want 1/01/0", rdy0, rs_tx0, rd_tx0); end
        cyc(); drv(0, 1, TR_NS, 32'h0, 0, 0); #2;
        tests++; if (rs_tx0 !== 2'b00) begin fails++; $display("FAIL oor_after_resp got %b want 00", rs_tx0); end
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 0); #2;
        tests++; if (rd_tx0 !== 32'hA5A5_0001) begin fails++; $display("FAIL oor_mem_kept got %h want a5a50001", rd_tx0); end
`else
        tests++; if ({rdy0, rs_tx0} !== 3'b100) begin fails++; $display("FAIL oor_wrap_resp got %b want 100", {rdy0, rs_tx0}); end
        tests++; if (rd_tx0 !== 32'hA5A5_0001) begin fails++; $display("FAIL oor_wrap_rdata got %h want a5a50001", rd_tx0); end
`endif
    endtask

    task automatic test_reset_abort();
        do_reset();
        cyc(); drv(0, 1, TR_NS, 32'h20, 1, 0);
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 32'h1111_2222);
        cyc(); cyc(); cyc(); #2;
        tests++; if (rdy3 !== 1'b1) begin fails++; $display("FAIL abort_first_wr got %b want 1", rdy3); end
        cyc(); drv(0, 1, TR_NS, 32'h20, 1, 0);
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 32'h9999_8888); #2;
        tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL abort_in_wait got %b want 0", rdy3); end
        #1 rst_n = 0;
        #1;
        tests++; if ({rdy3, g_tx3, g_rx3, rs_tx3, rs_rx3} !== 7'b1100000) begin fails++; $display("FAIL abort_async_ctl got %b want 1100000", {rdy3, g_tx3, g_rx3, rs_tx3, rs_rx3}); end
        tests++; if ({rd_tx3, rd_rx3} !== 64'h0) begin fails++; $display("FAIL abort_async_rdata got %h want 0", {rd_tx3, rd_rx3}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cyc(); drv(0, 1, TR_NS, 32'h20, 0, 0);
        cyc(); drv(0, 1, TR_IDLE, 0, 0, 0);
        cyc(); cyc(); cyc(); #2;
        tests++; if (rd_tx3 !== 32'h1111_2222) begin fails++; $display("FAIL abort_mem_kept got %h want 11112222", rd_tx3); end
    endtask

    initial begin
        rst_n = 0;
        idle_all();
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_burst_alternation();
        test_park();
        test_out_of_range();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
